// File: rtl/mips_pkg.sv
// Shared decode constants and types for the execute-stage multiply/divide unit.
package mips_pkg;

    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    typedef enum logic [1:0] {MD_IDLE, MD_ITER, MD_FIX} md_state_t;

    typedef enum logic [3:0] {
        MD_NONE, MD_MUL, MD_MULU, MD_DIV, MD_DIVU,
        MD_MFHI, MD_MFLO, MD_MTHI, MD_MTLO
    } md_op_t;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative datapath: operand magnitudes, shift-add multiply / restoring divide, sign fix.
// One result bit per step; res_hi/res_lo are valid once the last step has completed.
module muldiv_iter
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             step,
    input  md_op_t           op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             last,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);
    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   hi_r, lo_r, b_r;
    logic               is_div, neg_q, neg_r, divzero;

    logic               sgn, a_neg, b_neg;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic               div_ok;
    logic [2*WIDTH-1:0] prod_fix;

    always_comb begin
        sgn   = (op == MD_MUL) || (op == MD_DIV);
        a_neg = sgn & srca[WIDTH-1];
        b_neg = sgn & srcb[WIDTH-1];
        a_abs = a_neg ? -srca : srca;
        b_abs = b_neg ? -srcb : srcb;
    end

    // hi_r/lo_r are accumulator:multiplier for mul, remainder:dividend-shifting-into-quotient for div.
    always_comb begin
        mul_sum   = {1'b0, hi_r} + {1'b0, (lo_r[0] ? b_r : '0)};
        div_shift = {hi_r, lo_r[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_r};
        div_ok    = ~div_diff[WIDTH];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            hi_r    <= '0;
            lo_r    <= '0;
            b_r     <= '0;
            is_div  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            divzero <= 1'b0;
        end else if (start) begin
            count   <= CW'(WIDTH - 1);
            hi_r    <= '0;
            lo_r    <= a_abs;
            b_r     <= b_abs;
            is_div  <= (op == MD_DIV) || (op == MD_DIVU);
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= a_neg;
            divzero <= (srcb == '0);
        end else if (step) begin
            count <= count - CW'(1);
            if (is_div) begin
                hi_r <= div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                lo_r <= {lo_r[WIDTH-2:0], div_ok};
            end else begin
                hi_r <= mul_sum[WIDTH:1];
                lo_r <= {mul_sum[0], lo_r[WIDTH-1:1]};
            end
        end
    end

    assign last = (count == '0);

    // Divide by zero leaves remainder = |a|; re-signing it restores the original dividend.
    always_comb begin
        prod_fix = neg_q ? -{hi_r, lo_r} : {hi_r, lo_r};
        if (is_div) begin
            res_hi = neg_r ? -hi_r : hi_r;
            res_lo = divzero ? '1 : (neg_q ? -lo_r : lo_r);
        end else begin
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
            res_lo = prod_fix[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: funct decode, IDLE/ITER/FIX control, HI/LO registers, mfhi/mflo mux.
// Result lands WIDTH+1 cycles after acceptance; md ops stall while busy, other instructions never do.
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit ENABLE_DIV = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       aluop,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic             mdsel,
    output logic [WIDTH-1:0] mdresult,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    md_state_t        state, state_nxt;
    md_op_t           op;
    logic             rtype, accept, start, step, wr_res, last;
    logic [WIDTH-1:0] res_hi, res_lo;

    always_comb begin
        rtype   = en && (aluop == ALUOP_RTYPE);
        op      = MD_NONE;
        illegal = 1'b0;
        if (rtype) begin
            case (funct)
                FUNCT_MULT:  op = MD_MUL;
                FUNCT_MULTU: op = MD_MULU;
                FUNCT_DIV:   if (ENABLE_DIV) op = MD_DIV;  else illegal = 1'b1;
                FUNCT_DIVU:  if (ENABLE_DIV) op = MD_DIVU; else illegal = 1'b1;
                FUNCT_MFHI:  op = MD_MFHI;
                FUNCT_MFLO:  op = MD_MFLO;
                FUNCT_MTHI:  op = MD_MTHI;
                FUNCT_MTLO:  op = MD_MTLO;
                default:     op = MD_NONE;
            endcase
        end
        stall  = (op != MD_NONE) && busy;
        accept = (state == MD_IDLE) && (op != MD_NONE) && !stall;
        mdsel  = accept && ((op == MD_MFHI) || (op == MD_MFLO));
        if (op == MD_MFHI)      mdresult = hi;
        else if (op == MD_MFLO) mdresult = lo;
        else                    mdresult = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= MD_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MD_IDLE: if (start) state_nxt = MD_ITER;
            MD_ITER: if (last)  state_nxt = MD_FIX;
            MD_FIX:  state_nxt = MD_IDLE;
            default: state_nxt = MD_IDLE;
        endcase
    end

    always_comb begin
        start  = accept && ((op == MD_MUL) || (op == MD_MULU) ||
                            (op == MD_DIV) || (op == MD_DIVU));
        step   = (state == MD_ITER);
        wr_res = (state == MD_FIX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi   <= '0;
            lo   <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nxt != MD_IDLE);
            done <= wr_res;
            if (wr_res) begin
                hi <= res_hi;
                lo <= res_lo;
            end else if (accept && (op == MD_MTHI)) begin
                hi <= srca;
            end else if (accept && (op == MD_MTLO)) begin
                lo <= srca;
            end
        end
    end

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .step   (step),
        .op     (op),
        .srca   (srca),
        .srcb   (srcb),
        .last   (last),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

endmodule
